// File: rtl/frame_rx_pkg.sv
// Shared types and constants for the frame receiver.
//   DATA_WIDTH  payload bits per frame (LSB first on the line)
//   FRAME_BITS  line bits per frame: start + data + parity + stop
//   rx_state_t  receiver FSM state encoding
//   payload_t   payload word carried on received_data
package frame_rx_pkg;

  localparam int unsigned DATA_WIDTH = 15;
  localparam int unsigned FRAME_BITS = DATA_WIDTH + 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  typedef logic [DATA_WIDTH-1:0] payload_t;

  // Even parity holds when data bits plus parity bit XOR to zero.
  function automatic logic parity_ok(input payload_t data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/frame_rx_if.sv
// Bundle between the serial line, the receiver and the command decoder.
//   rx             serial line, idle high
//   received_data  last good payload
//   frame_valid    1-cycle pulse, received_data just updated
//   parity_err     1-cycle pulse, parity mismatch
//   frame_err      1-cycle pulse, stop bit low
//   busy           receiver is inside a frame (not IDLE)
// master: the receiver side; slave: line driver / payload consumer side.
interface frame_rx_if;
  import frame_rx_pkg::*;

  logic     rx;
  payload_t received_data;
  logic     frame_valid;
  logic     parity_err;
  logic     frame_err;
  logic     busy;

  modport master (
    input  rx,
    output received_data, frame_valid, parity_err, frame_err, busy
  );

  modport slave (
    output rx,
    input  received_data, frame_valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/frame_rx_bit_timer.sv
// Bit timer: down-counter that produces a sample tick once per line bit.
//   clk, rst   clock, async active-high reset
//   load_half  load CLKS_PER_BIT/2-1 so the first tick lands mid start bit
//   run        count while the receiver is inside a frame
//   tick_c     combinational: counter is at zero while running
// CLKS_PER_BIT must be even and at least 4.
module frame_rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load_half,
  input  logic run,
  output logic tick_c
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF   = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt_q;

  // Counter holds outside a frame; reloads a full bit period on each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_half) begin
      cnt_q <= HALF;
    end else if (run) begin
      cnt_q <= (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    end
  end

  assign tick_c = run & (cnt_q == '0);

endmodule

// File: rtl/frame_rx.sv
// Serial frame receiver: start, DATA_WIDTH data bits LSB first, even parity,
// stop. Publishes a clean payload with a frame_valid pulse, flags parity and
// framing errors with single-cycle pulses.
//   clk, rst  clock, async active-high reset
//   bus       frame_rx_if.master: rx in; received_data, frame_valid,
//             parity_err, frame_err, busy out (all registered)
module frame_rx
  import frame_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  frame_rx_if.master bus
);

  localparam int unsigned IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;
  localparam logic [2:0] S_BREAK  = BREAK;

  // Input synchronizer and falling-edge detect
  logic       sync1_q, sync2_q;
  logic [1:0] fill_q;
  logic       hist_q;
  logic       rx_s;
  logic       fall_c;

  assign rx_s = sync2_q;

  // fill_q flushes the reset value out of the synchronizer: history only
  // tracks rx_s once real line samples arrive, so a line that is already low
  // when rst falls is never mistaken for a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      hist_q  <= fill_q[1] ? sync2_q : 1'b0;
    end
  end

  assign fall_c = fill_q[1] & hist_q & ~rx_s;

  // Bit timer
  logic load_half_c;
  logic run_c;
  logic tick_c;

  frame_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_half(load_half_c),
    .run      (run_c),
    .tick_c   (tick_c)
  );

  // FSM and datapath registers
  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  payload_t      shift_q, shift_d;
  logic          par_q, par_d;
  payload_t      data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          busy_q;

  assign run_c = (state_q == S_START) || (state_q == S_DATA) ||
                 (state_q == S_PARITY) || (state_q == S_STOP);

  // Next-state, datapath and pulse logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    load_half_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall_c) begin
          load_half_c = 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        // Line back high at mid start bit: treat as a glitch.
        if (tick_c) begin
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Framing error outranks parity error.
        if (tick_c) begin
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end else if (parity_ok(shift_q, par_q)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        // Hold off until the line recovers so a stuck-low line cannot retrigger.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign bus.received_data = data_q;
  assign bus.frame_valid   = valid_q;
  assign bus.parity_err    = perr_q;
  assign bus.frame_err     = ferr_q;
  assign bus.busy          = busy_q;

endmodule
